// File: rtl/multi_alarm_pkg.sv
// multi_alarm_pkg: state encodings and shared constants for the multi-alarm key-entry controller
package multi_alarm_pkg;
  localparam int STATE_W = 3;
  localparam logic [3:0] NOKEY_DEF = 4'd10;
  typedef enum logic [STATE_W-1:0] {
    SHOW_TIME        = 3'd0,
    KEY_ENTRY        = 3'd1,
    KEY_STORED       = 3'd2,
    SHOW_ALARM       = 3'd3,
    SET_ALARM_TIME   = 3'd4,
    SET_CURRENT_TIME = 3'd5,
    KEY_WAITED       = 3'd6
  } state_t;
endpackage

// File: rtl/fsm_timeout_cnt.sv
// fsm_timeout_cnt: counts one_second pulses while enabled and flags the pulse that completes the window
module fsm_timeout_cnt #(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_one_second,
  output logic o_time_out
);
  localparam int TW = $clog2(TIMEOUT_SECS);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_SECS - 1);
  logic [TW-1:0] r_tcnt;
  assign o_time_out = i_enable && i_one_second && (r_tcnt == LAST);
  // window restarts on any state change or outside the timed states
  always_ff @(posedge i_clock)
    if (!i_reset || i_clear || !i_enable) r_tcnt <= '0;
    else if (i_one_second) r_tcnt <= r_tcnt + 1'b1;
endmodule

// File: rtl/multi_alarm_ctrl_fsm.sv
// multi_alarm_ctrl_fsm: Moore key-entry/alarm controller with selectable alarm register and entry-length check
module multi_alarm_ctrl_fsm
  import multi_alarm_pkg::*;
#(
  parameter int         NUM_ALARMS   = 4,
  parameter int         TIMEOUT_SECS = 10,
  parameter int         DIGITS       = 4,
  parameter logic [3:0] NOKEY        = NOKEY_DEF,
  localparam int        IW           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_one_second,
  input  logic [3:0]    i_key,
  input  logic          i_alarm_button,
  input  logic          i_time_button,
  input  logic          i_sel_button,
  output logic [IW-1:0] o_alarm_idx,
  output logic          o_show_new_time,
  output logic          o_show_a,
  output logic          o_load_new_a,
  output logic          o_load_new_c,
  output logic          o_reset_count,
  output logic          o_shift,
  output logic          o_entry_err
);
  localparam int DW = $clog2(DIGITS + 1);
  localparam logic [DW-1:0] D_FULL = DW'(DIGITS);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_ALARMS - 1);
  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_dcnt;
  logic [IW-1:0] r_idx;
  logic          r_sel_d;
  logic          r_err;
  logic          w_full;
  logic          w_time_out;
  assign w_full = (r_dcnt == D_FULL);
  fsm_timeout_cnt #(.TIMEOUT_SECS(TIMEOUT_SECS)) u_tcnt (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_next != r_state),
    .i_enable     (r_state == KEY_ENTRY || r_state == KEY_WAITED),
    .i_one_second (i_one_second),
    .o_time_out   (w_time_out)
  );
  // next-state selection; buttons outrank timeout, timeout outranks keys
  always_comb begin
    w_next = SHOW_TIME;
    case (r_state)
      SHOW_TIME:  w_next = i_alarm_button ? SHOW_ALARM : (i_key != NOKEY) ? KEY_STORED : SHOW_TIME;
      KEY_STORED: w_next = KEY_WAITED;
      KEY_WAITED: w_next = (i_key == NOKEY) ? KEY_ENTRY : w_time_out ? SHOW_TIME : KEY_WAITED;
      KEY_ENTRY:  w_next = i_alarm_button ? (w_full ? SET_ALARM_TIME : SHOW_TIME) :
                           i_time_button  ? (w_full ? SET_CURRENT_TIME : SHOW_TIME) :
                           w_time_out     ? SHOW_TIME :
                           (i_key != NOKEY && !w_full) ? KEY_STORED : KEY_ENTRY;
      SHOW_ALARM: w_next = i_alarm_button ? SHOW_ALARM : SHOW_TIME;
      default:    w_next = SHOW_TIME;
    endcase
  end
  // state, digit count, alarm selection and error pulse registers
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      r_state <= SHOW_TIME;
      r_dcnt  <= '0;
      r_idx   <= '0;
      r_sel_d <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dcnt  <= (r_state == SHOW_TIME) ? '0 : (r_state == KEY_STORED && !w_full) ? r_dcnt + 1'b1 : r_dcnt;
      r_sel_d <= i_sel_button;
      if (i_sel_button && !r_sel_d && r_state != SET_ALARM_TIME) r_idx <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
      r_err   <= (r_state == KEY_ENTRY) && (i_alarm_button || i_time_button) && !w_full;
    end
  assign o_alarm_idx     = r_idx;
  assign o_entry_err     = r_err;
  assign o_show_new_time = (r_state == KEY_ENTRY) || (r_state == KEY_STORED) || (r_state == KEY_WAITED);
  assign o_show_a        = (r_state == SHOW_ALARM);
  assign o_load_new_a    = (r_state == SET_ALARM_TIME);
  assign o_load_new_c    = (r_state == SET_CURRENT_TIME);
  assign o_reset_count   = (r_state == SET_CURRENT_TIME);
  assign o_shift         = (r_state == KEY_STORED);
endmodule
